axi_lite_write_regs: RTL

AXI_LITE_WRITE_REGS -- requirements
Module: axi_lite_write_regs

---
 rtl/axi_lite_pkg.sv | 13 +
 rtl/axi_lite_regfile.sv | 49 ++++
 rtl/axi_lite_write_regs.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and address LSB helper.
// Used by the write-register block and its register file.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Number of byte-offset address bits for a bus of data_w bits.
  function automatic int lsb_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// Register file with byte-strobe merged writes, synchronous active-low reset.
// Ports: ACLK, ARESETn, we, idx, data, strb in; flattened regs_out out.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic                       we,
  input  logic [IDX_W-1:0]           idx,
  input  logic [DATA_W-1:0]          data,
  input  logic [DATA_W/8-1:0]        strb,
  output logic [NUM_REGS*DATA_W-1:0] regs_out
);

  localparam int STRB_W = DATA_W / 8;

  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic [NUM_REGS*DATA_W-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx == IDX_W'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
              regs_d[i*DATA_W + b*8 +: 8] = data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign regs_out = regs_q;

endmodule

// File: rtl/axi_lite_write_regs.sv
// AXI-Lite write-only slave: single AW and W slots, commit into a regfile.
// Ports: AXI AW/W/B channels, flattened regs_out, wr_pulse, wr_index.
module axi_lite_write_regs
  import axi_lite_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 8
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETn,
  input  logic [ADDR_W-1:0]                    AWADDR,
  input  logic                                 AWVALID,
  output logic                                 AWREADY,
  input  logic [DATA_W-1:0]                    WDATA,
  input  logic [DATA_W/8-1:0]                  WSTRB,
  input  logic                                 WVALID,
  output logic                                 WREADY,
  output logic [1:0]                           BRESP,
  output logic                                 BVALID,
  input  logic                                 BREADY,
  output logic [NUM_REGS*DATA_W-1:0]           regs_out,
  output logic                                 wr_pulse,
  output logic [ADDR_W-lsb_w(DATA_W)-1:0]      wr_index
);

  localparam int LSB    = lsb_w(DATA_W);
  localparam int IDX_W  = ADDR_W - LSB;
  localparam int STRB_W = DATA_W / 8;

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_dw
    $error("DATA_W must be 32 or 64");
  end
  if (NUM_REGS > (1 << IDX_W)) begin : g_bad_nr
    $error("NUM_REGS exceeds address space");
  end

  logic              aw_full_q, aw_full_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic              w_full_q, w_full_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [IDX_W-1:0]  wr_index_q, wr_index_d;

  logic aw_hs, w_hs, commit, idx_ok;

  // Byte-offset bits are dropped: unaligned addresses act aligned.
  logic unused_lsb;
  assign unused_lsb = ^AWADDR[LSB-1:0];

  always_comb begin
    aw_hs  = AWVALID & awready_q;
    w_hs   = WVALID & wready_q;
    idx_ok = 32'(aw_idx_q) < NUM_REGS;
    // A pending response that is not being accepted blocks the commit.
    commit = aw_full_q & w_full_q & (~bvalid_q | BREADY);

    aw_full_d  = aw_full_q;
    aw_idx_d   = aw_idx_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_index_d = wr_index_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = AWADDR[ADDR_W-1:LSB];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end

    if (commit) begin
      aw_full_d  = 1'b0;
      w_full_d   = 1'b0;
      bvalid_d   = 1'b1;
      bresp_d    = idx_ok ? RESP_OKAY : RESP_SLVERR;
      wr_index_d = aw_idx_q;
    end else if (bvalid_q & BREADY) begin
      bvalid_d = 1'b0;
    end

    wr_pulse_d = commit & idx_ok;
    awready_d  = ~aw_full_d;
    wready_d   = ~w_full_d;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
    end else begin
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      wr_index_q <= wr_index_d;
    end
  end

  axi_lite_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .IDX_W   (IDX_W)
  ) u_regfile (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .we      (commit & idx_ok),
    .idx     (aw_idx_q),
    .data    (w_data_q),
    .strb    (w_strb_q),
    .regs_out(regs_out)
  );

  assign AWREADY  = awready_q;
  assign WREADY   = wready_q;
  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_index = wr_index_q;

endmodule
